// File: rtl/handshake_cdc_sender.sv
// Send side of a 4-phase req/ack crossing: holds one accepted word on o_data
// while req/ack runs through a full cycle, then accepts the next word.
module handshake_cdc_sender #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_req,
  input  logic                  i_ack,
  output logic                  o_done,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_xfer_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  req_q,   req_d;
  logic                  done_q,  done_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    count_d = count_q;
    o_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A stale ack left over from an interrupted transfer blocks new words.
        o_ready = !i_ack;
        if (i_valid && !i_ack) begin
          data_d  = i_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_ack) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          count_d = count_q + 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!i_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data       = data_q;
  assign o_req        = req_q;
  assign o_done       = done_q;
  assign o_busy       = (state_q != IDLE);
  assign o_xfer_count = count_q;

endmodule

// File: tb/tb_handshake_cdc_sender.sv
// Directed bench for handshake_cdc_sender: default instance plus a 2-bit
// counter instance for the wrap case.
module tb_handshake_cdc_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [31:0] din;
  logic [31:0] dout;
  logic        req;
  logic        ack;
  logic        ack_drv;
  logic        echo;
  logic        done;
  logic        busy;
  logic [15:0] cnt;

  logic        valid2;
  logic        ready2;
  logic [7:0]  din2;
  logic [7:0]  dout2;
  logic        req2;
  logic        done2;
  logic        busy2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ack = echo ? req : ack_drv;

  handshake_cdc_sender u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_data(din), .o_data(dout), .o_req(req), .i_ack(ack),
    .o_done(done), .o_busy(busy), .o_xfer_count(cnt)
  );

  handshake_cdc_sender #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid2), .o_ready(ready2),
    .i_data(din2), .o_data(dout2), .o_req(req2), .i_ack(req2),
    .o_done(done2), .o_busy(busy2), .o_xfer_count(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; din = '0; ack_drv = 1'b0; echo = 1'b0;
    valid2 = 1'b0; din2 = '0;
    step();
    check("rst_req", req, 0);
    check("rst_data", dout, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // 1: single word with delayed ack/release
    valid = 1'b1; din = 32'hDEADBEEF;
    #1 check("t1_ready_idle", ready, 1);
    step();
    valid = 1'b0;
    check("t1_req", req, 1);
    check("t1_data", dout, 32'hDEADBEEF);
    check("t1_ready_req", ready, 0);
    check("t1_busy", busy, 1);
    step();
    check("t1_no_early_done", done, 0);
    ack_drv = 1'b1;
    step();
    check("t1_req_fall", req, 0);
    check("t1_done", done, 1);
    check("t1_cnt", cnt, 1);
    step();
    check("t1_done_once", done, 0);
    check("t1_hold_release", busy, 1);
    step();
    ack_drv = 1'b0;
    #1 check("t1_ready_release", ready, 0);
    step();
    check("t1_ready_again", ready, 1);
    check("t1_idle", busy, 0);
    check("t1_cnt_hold", cnt, 1);

    // 2: back-to-back words with combinational ack echo
    do_reset();
    echo = 1'b1; valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din = k;
      #1 check($sformatf("t2_ready_%0d", k), ready, 1);
      step();
      din = 32'hFFFF_0000;
      check($sformatf("t2_data_%0d", k), dout, k);
      check($sformatf("t2_req_%0d", k), req, 1);
      step();
      check($sformatf("t2_done_%0d", k), done, 1);
      check($sformatf("t2_ready_rel_%0d", k), ready, 0);
      step();
      check($sformatf("t2_done_low_%0d", k), done, 0);
    end
    valid = 1'b0;
    check("t2_cnt", cnt, 4);
    check("t2_last_data", dout, 4);
    echo = 1'b0;

    // 3: stale ack present at reset release
    ack_drv = 1'b1;
    do_reset();
    valid = 1'b1; din = 32'h0000_3333;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_ready_stale", ready, 0);
      step();
      check("t3_req_stale", req, 0);
      check("t3_busy_stale", busy, 0);
    end
    ack_drv = 1'b0;
    #1 check("t3_ready_clear", ready, 1);
    step();
    valid = 1'b0;
    check("t3_accept", req, 1);
    check("t3_data", dout, 32'h0000_3333);
    ack_drv = 1'b1;
    step();
    check("t3_done", done, 1);
    ack_drv = 1'b0;
    step();
    check("t3_cnt", cnt, 1);

    // 4: data churn during REQ/RELEASE; ack already low entering RELEASE
    valid = 1'b1; din = 32'hA5A5_A5A5;
    step();
    for (int i = 0; i < 3; i++) begin
      din = 32'h1000 + i;
      step();
      check("t4_data_req", dout, 32'hA5A5_A5A5);
      check("t4_no_done", done, 0);
      check("t4_in_req", req, 1);
    end
    ack_drv = 1'b1;
    step();
    check("t4_done", done, 1);
    ack_drv = 1'b0; din = 32'h7777_7777;
    step();
    check("t4_data_rel", dout, 32'hA5A5_A5A5);
    check("t4_back_idle", busy, 0);
    valid = 1'b0;
    step();
    check("t4_cnt", cnt, 2);

    // 5: reset mid-transfer
    valid = 1'b1; din = 32'h5555_0005;
    step();
    valid = 1'b0;
    check("t5_in_req", req, 1);
    rst = 1'b1;
    #1;
    check("t5_req_async", req, 0);
    check("t5_cnt_async", cnt, 0);
    check("t5_busy_async", busy, 0);
    step();
    rst = 1'b0;

    // 6: 2-bit counter wrap
    valid2 = 1'b1; din2 = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      while (!done2 && n < 10) begin
        step();
        n++;
      end
      check($sformatf("t6_done_seen_%0d", k), done2, 1);
      check($sformatf("t6_cnt_%0d", k), cnt2, (k + 1) % 4);
      step();
    end
    valid2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
